// File: rtl/bist_pkg.sv
// Shared state encoding and default widths for the sequenced BIST controller.
package bist_pkg;

  localparam int unsigned N_WIDTH_DEF = 3;
  localparam int unsigned M_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bist_seq_controller_if.sv
// Test-access / CUT-side bundle of the BIST controller.
// Optional macro BIST_ABORT_EN adds the abort request and BIST_ABORTED status.
interface bist_seq_controller_if
  import bist_pkg::*;
#(
  parameter int unsigned N_WIDTH = N_WIDTH_DEF,
  parameter int unsigned M_WIDTH = M_WIDTH_DEF
);

  logic               start;
  logic [N_WIDTH-1:0] n_len;
  logic [M_WIDTH-1:0] m_len;
  logic               Running;
  logic               OUT;
  logic               BIST_END;
  logic [M_WIDTH-1:0] round_idx;
`ifdef BIST_ABORT_EN
  logic               abort;
  logic               BIST_ABORTED;

  modport master (output start, n_len, m_len, abort,
                  input  Running, OUT, BIST_END, round_idx, BIST_ABORTED);
  modport slave  (input  start, n_len, m_len, abort,
                  output Running, OUT, BIST_END, round_idx, BIST_ABORTED);
`else
  modport master (output start, n_len, m_len,
                  input  Running, OUT, BIST_END, round_idx);
  modport slave  (input  start, n_len, m_len,
                  output Running, OUT, BIST_END, round_idx);
`endif

endinterface

// File: rtl/bist_counter.sv
// Up-counter with synchronous clear and a terminal flag at limit-1.
module bist_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  // Clear takes priority over enable so the wrap back to zero is one edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // Limits are latched >= 1 whenever this flag is consumed, so no underflow case matters.
  assign terminal = (count == limit - WIDTH'(1));

endmodule

// File: rtl/bist_seq_controller.sv
// Run-time configurable BIST sequencer: m_len rounds of n_len stimulus cycles plus one gap.
// Optional macro BIST_ABORT_EN adds an abort request that ends the test early.
module bist_seq_controller
  import bist_pkg::*;
#(
  parameter int unsigned N_WIDTH = N_WIDTH_DEF,
  parameter int unsigned M_WIDTH = M_WIDTH_DEF
) (
  input logic                  clk,
  input logic                  reset,
  bist_seq_controller_if.slave bus
);

  state_e             state;
  state_e             state_next;
  logic               s1;
  logic               s2;
  logic               launch;
  logic [N_WIDTH-1:0] n_lat;
  logic [M_WIDTH-1:0] m_lat;
  logic [N_WIDTH-1:0] unused_cnt_n;
  logic [M_WIDTH-1:0] cnt_m;
  logic               n_term;
  logic               m_term;
  logic               n_clear;
  logic               n_en;
  logic               m_clear;
  logic               m_en;
  logic               aborted_next;

  // Stimulus-cycle counter within a round.
  bist_counter #(.WIDTH(N_WIDTH)) u_cnt_n (
    .clk      (clk),
    .reset    (reset),
    .clear    (n_clear),
    .enable   (n_en),
    .limit    (n_lat),
    .count    (unused_cnt_n),
    .terminal (n_term)
  );

  // Round counter; its value is exported directly as round_idx.
  bist_counter #(.WIDTH(M_WIDTH)) u_cnt_m (
    .clk      (clk),
    .reset    (reset),
    .clear    (m_clear),
    .enable   (m_en),
    .limit    (m_lat),
    .count    (cnt_m),
    .terminal (m_term)
  );

  assign bus.round_idx = cnt_m;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Two-stage start shift used for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.start;
      s2 <= s1;
    end
  end

  // Lengths are frozen at launch; a zero stimulus length runs as one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_lat <= '0;
      m_lat <= '0;
    end else if (launch) begin
      n_lat <= (bus.n_len == '0) ? N_WIDTH'(1) : bus.n_len;
      m_lat <= bus.m_len;
    end
  end

  // Next-state and counter control.
  always_comb begin
    state_next   = state;
    launch       = 1'b0;
    n_clear      = 1'b0;
    n_en         = 1'b0;
    m_clear      = 1'b0;
    m_en         = 1'b0;
    aborted_next = 1'b0;

    case (state)
      IDLE: begin
        launch = s1 & ~s2;
        if (launch) begin
          n_clear    = 1'b1;
          m_clear    = 1'b1;
          state_next = (bus.m_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (n_term) begin
          n_clear    = 1'b1;
          state_next = GAP;
        end else begin
          n_en = 1'b1;
        end
      end
      GAP: begin
        if (m_term) begin
          state_next = DONE;
        end else begin
          m_en       = 1'b1;
          state_next = RUN;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef BIST_ABORT_EN
    // Abort overrides normal sequencing, including the final gap; round_idx is frozen.
    if (bus.abort && (state == RUN || state == GAP)) begin
      state_next   = DONE;
      aborted_next = 1'b1;
      n_clear      = 1'b0;
      n_en         = 1'b0;
      m_en         = 1'b0;
    end
`endif
  end

  // Outputs registered from the next-state decode so they track the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.Running  <= 1'b0;
      bus.OUT      <= 1'b0;
      bus.BIST_END <= 1'b0;
    end else begin
      bus.Running  <= (state_next == RUN) || (state_next == GAP);
      bus.OUT      <= (state_next == RUN);
      bus.BIST_END <= (state_next == DONE);
    end
  end

`ifdef BIST_ABORT_EN
  // Aborted flag accompanies BIST_END for the single DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.BIST_ABORTED <= 1'b0;
    end else begin
      bus.BIST_ABORTED <= aborted_next;
    end
  end
`else
  logic unused_aborted;
  assign unused_aborted = aborted_next;
`endif

endmodule

// File: tb/tb_bist_seq_controller.sv
// Self-checking bench: per-cycle comparison against a schedule-based reference model.
module tb_bist_seq_controller;

  localparam int unsigned NW = 3;
  localparam int unsigned MW = 4;

  typedef struct packed {
    logic          running;
    logic          out;
    logic          bend;
    logic          aborted;
    logic [MW-1:0] round;
  } exp_t;

  logic clk;
  logic reset;
  logic abort_drv;

  bist_seq_controller_if #(.N_WIDTH(NW), .M_WIDTH(MW)) bif ();

`ifdef BIST_ABORT_EN
  assign bif.abort = abort_drv;
`endif

  bist_seq_controller #(.N_WIDTH(NW), .M_WIDTH(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_fail = 0;
  int   run_cnt = 0;
  int   end_cnt = 0;
  int   abt_cnt = 0;
  logic p1 = 1'b0;
  logic p2 = 1'b0;
  logic cur_idle = 1'b1;
  exp_t cur = '0;
  exp_t exp_q[$];

  task automatic chk_num(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole-test expectation: m rounds of (n stimulus + 1 gap) then one DONE cycle.
  task automatic build(input int n, input int m);
    int neff;
    neff = (n == 0) ? 1 : n;
    for (int r = 0; r < m; r++) begin
      for (int i = 0; i < neff; i++) exp_q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, MW'(r)});
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, MW'(r)});
    end
    exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, (m == 0) ? MW'(0) : MW'(m - 1)});
  endtask

  // Reference model advanced once per rising edge with the inputs seen at that edge.
  task automatic model_edge(input logic r, input logic st, input int n, input int m, input logic ab);
    logic launch;
    if (r) begin
      exp_q.delete();
      p1 = 1'b0;
      p2 = 1'b0;
      cur = '0;
      cur_idle = 1'b1;
      return;
    end
    launch = p1 && !p2 && cur_idle;
    if (ab && cur.running) begin
      exp_q.delete();
      cur = '{1'b0, 1'b0, 1'b1, 1'b1, cur.round};
      cur_idle = 1'b0;
    end else begin
      if (launch) build(n, m);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        cur_idle = 1'b0;
      end else begin
        cur.running = 1'b0;
        cur.out     = 1'b0;
        cur.bend    = 1'b0;
        cur.aborted = 1'b0;
        cur_idle    = 1'b1;
      end
    end
    p2 = p1;
    p1 = st;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(reset, bif.start, int'(bif.n_len), int'(bif.m_len), abort_drv);
    #1;
    chk_bit("running", bif.Running, cur.running);
    chk_bit("out", bif.OUT, cur.out);
    chk_bit("bist_end", bif.BIST_END, cur.bend);
    chk_num("round_idx", int'(bif.round_idx), int'(cur.round));
`ifdef BIST_ABORT_EN
    chk_bit("bist_aborted", bif.BIST_ABORTED, cur.aborted);
    if (bif.BIST_ABORTED === 1'b1) abt_cnt++;
`endif
    if (bif.Running === 1'b1) run_cnt++;
    if (bif.BIST_END === 1'b1) end_cnt++;
  endtask

  // One start pulse; checks launch latency, total Running cycles and a single END pulse.
  task automatic pulse_test(input int n, input int m);
    int neff;
    int exp_run;
    int first;
    neff    = (n == 0) ? 1 : n;
    exp_run = m * (neff + 1);
    first   = 0;
    run_cnt = 0;
    end_cnt = 0;
    bif.n_len = NW'(n);
    bif.m_len = MW'(m);
    bif.start = 1'b1;
    for (int i = 1; i <= exp_run + 6; i++) begin
      step();
      if (i == 1) bif.start = 1'b0;
      if (first == 0 && (bif.Running === 1'b1 || bif.BIST_END === 1'b1)) first = i;
    end
    chk_num("launch_latency", first, 2);
    chk_num("running_total", run_cnt, exp_run);
    chk_num("end_pulses", end_cnt, 1);
  endtask

  initial begin
    reset     = 1'b1;
    abort_drv = 1'b0;
    bif.start = 1'b1;
    bif.n_len = NW'(3);
    bif.m_len = MW'(2);

    // Reset held with start high; release with start still high launches one test.
    repeat (3) step();
    run_cnt = 0;
    end_cnt = 0;
    reset = 1'b0;
    repeat (14) step();
    chk_num("post_reset_running", run_cnt, 8);
    chk_num("post_reset_end", end_cnt, 1);
    bif.start = 1'b0;
    repeat (2) step();

    // Nominal and boundary lengths.
    pulse_test(3, 2);
    pulse_test(0, 1);
    pulse_test(2, 0);
    pulse_test(7, 15);

    // Start held high: exactly one test.
    run_cnt = 0;
    end_cnt = 0;
    bif.n_len = NW'(2);
    bif.m_len = MW'(2);
    bif.start = 1'b1;
    repeat (50) step();
    chk_num("held_running", run_cnt, 6);
    chk_num("held_end", end_cnt, 1);
    bif.start = 1'b0;
    repeat (2) step();

    // Re-pulse during Running is ignored; a pulse after IDLE starts a second test.
    run_cnt = 0;
    end_cnt = 0;
    bif.n_len = NW'(3);
    bif.m_len = MW'(2);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    repeat (3) step();
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    repeat (10) step();
    chk_num("repulse_running", run_cnt, 8);
    chk_num("repulse_end", end_cnt, 1);
    pulse_test(1, 3);

    // Reset in round 1 RUN aborts silently.
    bif.n_len = NW'(3);
    bif.m_len = MW'(3);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    repeat (5) step();
    chk_num("pre_reset_round", int'(bif.round_idx), 1);
    end_cnt = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    chk_num("reset_mid_end", end_cnt, 0);

    // Lengths changed after launch do not affect the running test.
    run_cnt = 0;
    end_cnt = 0;
    bif.n_len = NW'(2);
    bif.m_len = MW'(3);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    repeat (3) step();
    bif.n_len = NW'(7);
    bif.m_len = MW'(1);
    repeat (10) step();
    chk_num("len_change_running", run_cnt, 9);
    chk_num("len_change_end", end_cnt, 1);

    // Randomized lengths and idle spacing.
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 3)) step();
      pulse_test(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)));
    end

`ifdef BIST_ABORT_EN
    // Abort in round 0 stimulus cycle 2.
    run_cnt = 0;
    end_cnt = 0;
    abt_cnt = 0;
    bif.n_len = NW'(4);
    bif.m_len = MW'(3);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    repeat (3) step();
    abort_drv = 1'b1;
    step();
    abort_drv = 1'b0;
    repeat (4) step();
    chk_num("abort_running", run_cnt, 3);
    chk_num("abort_end", end_cnt, 1);
    chk_num("abort_flag", abt_cnt, 1);

    // Abort coinciding with the final gap still reports aborted.
    run_cnt = 0;
    end_cnt = 0;
    abt_cnt = 0;
    bif.n_len = NW'(1);
    bif.m_len = MW'(1);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    repeat (2) step();
    abort_drv = 1'b1;
    step();
    abort_drv = 1'b0;
    repeat (3) step();
    chk_num("abort_gap_running", run_cnt, 2);
    chk_num("abort_gap_end", end_cnt, 1);
    chk_num("abort_gap_flag", abt_cnt, 1);

    // Random abort points checked cycle by cycle against the model.
    for (int k = 0; k < 6; k++) begin
      bif.n_len = NW'($urandom_range(0, 7));
      bif.m_len = MW'($urandom_range(1, 4));
      bif.start = 1'b1;
      step();
      bif.start = 1'b0;
      repeat ($urandom_range(1, 12)) step();
      abort_drv = 1'b1;
      step();
      abort_drv = 1'b0;
      repeat (40) step();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
